// File: rtl/issue_queue_ooo.sv
// Out-of-order issue queue: one enqueue per cycle into any free slot, two-source wakeup, registered issue, redirect squash.
// Optional ISSUE_QUEUE_AGE_SELECT_EN: oldest-ready select via an age matrix; otherwise lowest-index ready select.
module issue_queue_ooo #(
  parameter int DEPTH     = 8,
  parameter int WB_PORTS  = 2,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 160
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [PREG_W-1:0]            enq_prs1,
  input  logic [PREG_W-1:0]            enq_prs2,
  input  logic                         enq_src1_is_reg,
  input  logic                         enq_src2_is_reg,
  input  logic                         enq_src1_busy,
  input  logic                         enq_src2_busy,
  input  logic                         enq_robidx_flag,
  input  logic [ROB_W-1:0]             enq_robidx,
  input  logic [PAYLOAD_W-1:0]         enq_payload,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [PREG_W-1:0]            deq_prs1,
  output logic [PREG_W-1:0]            deq_prs2,
  output logic                         deq_src1_is_reg,
  output logic                         deq_src2_is_reg,
  output logic                         deq_robidx_flag,
  output logic [ROB_W-1:0]             deq_robidx,
  output logic [PAYLOAD_W-1:0]         deq_payload,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]   wb_prd,
  input  logic                         flush_valid,
  input  logic                         flush_robidx_flag,
  input  logic [ROB_W-1:0]             flush_robidx,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     ent_valid, ent_busy1, ent_busy2, ent_is_reg1, ent_is_reg2, ent_flag;
  logic [PREG_W-1:0]    ent_prs1    [DEPTH];
  logic [PREG_W-1:0]    ent_prs2    [DEPTH];
  logic [ROB_W-1:0]     ent_robidx  [DEPTH];
  logic [PAYLOAD_W-1:0] ent_payload [DEPTH];

  logic [DEPTH-1:0] ready, kill, wake1, wake2;
  logic [IDX_W-1:0] alloc_idx, sel_idx;
  logic             sel_valid, enq_wake1, enq_wake2, do_enq, do_sel;

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  // older[i][j] set means entry j was enqueued before entry i
  logic [DEPTH-1:0] older [DEPTH];
`endif

  assign enq_ready = ~&ent_valid;
  assign ready     = ent_valid & ~ent_busy1 & ~ent_busy2;
  assign do_enq    = enq_valid & enq_ready & ~flush_valid;
  assign do_sel    = deq_ready & ~flush_valid & sel_valid;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!ent_valid[i]) alloc_idx = IDX_W'(i);
  end

  always_comb begin
    enq_wake1 = 1'b0;
    enq_wake2 = 1'b0;
    wake1     = '0;
    wake2     = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == enq_prs1) enq_wake1 = 1'b1;
      if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == enq_prs2) enq_wake2 = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid[k] && ent_is_reg1[i] && ent_prs1[i] == wb_prd[k*PREG_W +: PREG_W]) wake1[i] = 1'b1;
        if (wb_valid[k] && ent_is_reg2[i] && ent_prs2[i] == wb_prd[k*PREG_W +: PREG_W]) wake2[i] = 1'b1;
      end
    end
  end

  // Younger-than-flush test: flag mismatch inverts the plain index compare
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++)
      kill[i] = flush_valid & ent_valid[i] &
                ((flush_robidx_flag ^ ent_flag[i]) ^ (flush_robidx < ent_robidx[i]));
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
    for (int i = 0; i < DEPTH; i++)
      if (ready[i] && !(|(ready & older[i]))) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`else
    for (int i = DEPTH-1; i >= 0; i--)
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + OCC_W'(ent_valid[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid       <= '0;
      ent_busy1       <= '0;
      ent_busy2       <= '0;
      ent_is_reg1     <= '0;
      ent_is_reg2     <= '0;
      ent_flag        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_prs1[i]    <= '0;
        ent_prs2[i]    <= '0;
        ent_robidx[i]  <= '0;
        ent_payload[i] <= '0;
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
        older[i]       <= '0;
`endif
      end
      deq_valid       <= 1'b0;
      deq_prs1        <= '0;
      deq_prs2        <= '0;
      deq_src1_is_reg <= 1'b0;
      deq_src2_is_reg <= 1'b0;
      deq_robidx_flag <= 1'b0;
      deq_robidx      <= '0;
      deq_payload     <= '0;
    end else begin
      ent_busy1 <= ent_busy1 & ~wake1;
      ent_busy2 <= ent_busy2 & ~wake2;
      ent_valid <= ent_valid & ~kill;
      deq_valid <= do_sel;
      if (do_sel) begin
        ent_valid[sel_idx] <= 1'b0;
        deq_prs1           <= ent_prs1[sel_idx];
        deq_prs2           <= ent_prs2[sel_idx];
        deq_src1_is_reg    <= ent_is_reg1[sel_idx];
        deq_src2_is_reg    <= ent_is_reg2[sel_idx];
        deq_robidx_flag    <= ent_flag[sel_idx];
        deq_robidx         <= ent_robidx[sel_idx];
        deq_payload        <= ent_payload[sel_idx];
      end
      // Allocated slot is always invalid, so it never collides with select or kill
      if (do_enq) begin
        ent_valid[alloc_idx]   <= 1'b1;
        ent_busy1[alloc_idx]   <= enq_src1_busy & enq_src1_is_reg & ~enq_wake1;
        ent_busy2[alloc_idx]   <= enq_src2_busy & enq_src2_is_reg & ~enq_wake2;
        ent_is_reg1[alloc_idx] <= enq_src1_is_reg;
        ent_is_reg2[alloc_idx] <= enq_src2_is_reg;
        ent_flag[alloc_idx]    <= enq_robidx_flag;
        ent_prs1[alloc_idx]    <= enq_prs1;
        ent_prs2[alloc_idx]    <= enq_prs2;
        ent_robidx[alloc_idx]  <= enq_robidx;
        ent_payload[alloc_idx] <= enq_payload;
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
        older[alloc_idx] <= ent_valid;
        for (int j = 0; j < DEPTH; j++)
          if (j != int'(alloc_idx)) older[j][alloc_idx] <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed bench for issue_queue_ooo at default parameters; expectations follow ISSUE_QUEUE_AGE_SELECT_EN when defined.
module tb_issue_queue_ooo;

  localparam int DEPTH = 8, WB_PORTS = 2, PREG_W = 6, ROB_W = 6, PAYLOAD_W = 160;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       enq_valid, enq_ready;
  logic [PREG_W-1:0]          enq_prs1, enq_prs2;
  logic                       enq_src1_is_reg, enq_src2_is_reg, enq_src1_busy, enq_src2_busy;
  logic                       enq_robidx_flag;
  logic [ROB_W-1:0]           enq_robidx;
  logic [PAYLOAD_W-1:0]       enq_payload;
  logic                       deq_valid, deq_ready;
  logic [PREG_W-1:0]          deq_prs1, deq_prs2;
  logic                       deq_src1_is_reg, deq_src2_is_reg, deq_robidx_flag;
  logic [ROB_W-1:0]           deq_robidx;
  logic [PAYLOAD_W-1:0]       deq_payload;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*PREG_W-1:0] wb_prd;
  logic                       flush_valid, flush_robidx_flag;
  logic [ROB_W-1:0]           flush_robidx;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  issue_queue_ooo #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .PREG_W(PREG_W), .ROB_W(ROB_W),
                    .PAYLOAD_W(PAYLOAD_W)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
    .enq_src1_busy(enq_src1_busy), .enq_src2_busy(enq_src2_busy),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx), .enq_payload(enq_payload),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_prs1(deq_prs1), .deq_prs2(deq_prs2),
    .deq_src1_is_reg(deq_src1_is_reg), .deq_src2_is_reg(deq_src2_is_reg),
    .deq_robidx_flag(deq_robidx_flag), .deq_robidx(deq_robidx), .deq_payload(deq_payload),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic [PAYLOAD_W-1:0] pl(input logic [ROB_W-1:0] idx);
    pl = (PAYLOAD_W'(idx) << 100) | PAYLOAD_W'(32'h5A5A_0000) | PAYLOAD_W'(idx);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic flag, input logic [ROB_W-1:0] idx,
                     input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                     input logic r1, input logic r2, input logic b1, input logic b2);
    enq_valid       = 1'b1;
    enq_robidx_flag = flag;
    enq_robidx      = idx;
    enq_prs1        = p1;
    enq_prs2        = p2;
    enq_src1_is_reg = r1;
    enq_src2_is_reg = r2;
    enq_src1_busy   = b1;
    enq_src2_busy   = b2;
    enq_payload     = pl(idx);
  endtask

  task automatic deq_check(input string tag, input logic flag, input logic [ROB_W-1:0] idx);
    check({tag, "_valid"}, 64'(deq_valid), 64'd1);
    check({tag, "_robidx"}, 64'({deq_robidx_flag, deq_robidx}), 64'({flag, idx}));
    check({tag, "_payload"}, 64'(deq_payload === pl(idx)), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    enq_valid = 1'b0; enq_prs1 = '0; enq_prs2 = '0; enq_src1_is_reg = 1'b0; enq_src2_is_reg = 1'b0;
    enq_src1_busy = 1'b0; enq_src2_busy = 1'b0; enq_robidx_flag = 1'b0; enq_robidx = '0;
    enq_payload = '0; deq_ready = 1'b0; wb_valid = '0; wb_prd = '0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0;
    step(); step();
    reset = 1'b0;
    step();

    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_robidx", 64'({deq_robidx_flag, deq_robidx}), 64'd0);
    check("rst_deq_payload", 64'(deq_payload === '0), 64'd1);

    // In-order stream robidx 0..3, all ready
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq(1'b0, ROB_W'(k), 6'd1, 6'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      if (k == 0) check("stream_first_lat", 64'(deq_valid), 64'd0);
      else deq_check("stream", 1'b0, ROB_W'(k-1));
      check("stream_occ", 64'(occupancy), 64'd1);
    end
    enq_valid = 1'b0;
    step();
    deq_check("stream", 1'b0, 6'd3);
    check("stream_occ_end", 64'(occupancy), 64'd0);
    step();
    check("stream_idle", 64'(deq_valid), 64'd0);

    // Fill with busy prs1=5, then one wakeup on port 1 releases all
    for (int k = 0; k < DEPTH; k++) begin
      enq(1'b0, ROB_W'(8+k), 6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      check("fill_hold", 64'(deq_valid), 64'd0);
    end
    enq_valid = 1'b0;
    check("full_occ", 64'(occupancy), 64'd8);
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    wb_valid = 2'b10;
    wb_prd   = {6'd5, 6'd0};
    step();
    wb_valid = '0;
    wb_prd   = '0;
    check("wake_lat", 64'(deq_valid), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      step();
      deq_check("wake_drain", 1'b0, ROB_W'(8+k));
      check("wake_occ", 64'(occupancy), 64'(DEPTH-1-k));
      if (k == 0) check("freed_enq_ready", 64'(enq_ready), 64'd1);
    end
    step();
    check("wake_idle", 64'(deq_valid), 64'd0);

    // Same-cycle wakeup at enqueue on src2
    enq(1'b0, 6'd20, 6'd3, 6'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    wb_valid = 2'b01;
    wb_prd   = {6'd0, 6'd9};
    step();
    enq_valid = 1'b0;
    wb_valid  = '0;
    wb_prd    = '0;
    check("enqwake_lat", 64'(deq_valid), 64'd0);
    step();
    deq_check("enqwake", 1'b0, 6'd20);
    check("enqwake_prs2", 64'(deq_prs2), 64'd9);
    check("enqwake_isreg", 64'({deq_src1_is_reg, deq_src2_is_reg}), 64'b01);

    // Busy flag on a non-register source is ignored
    enq(1'b0, 6'd21, 6'd7, 6'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    enq_valid = 1'b0;
    step();
    deq_check("notreg", 1'b0, 6'd21);
    step();

    // Age: A busy in slot 0, B ready in slot 1, A woken and issued, C refills slot 0
    deq_ready = 1'b0;
    enq(1'b0, 6'd30, 6'd7, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    enq(1'b0, 6'd31, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq_valid = 1'b0;
    wb_valid  = 2'b01;
    wb_prd    = {6'd0, 6'd7};
    step();
    wb_valid  = '0;
    wb_prd    = '0;
    deq_ready = 1'b1;
    step();
    deq_check("age_a", 1'b0, 6'd30);
    deq_ready = 1'b0;
    enq(1'b0, 6'd32, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq_valid = 1'b0;
    check("age_hold", 64'(deq_valid), 64'd0);
    check("age_occ", 64'(occupancy), 64'd2);
    deq_ready = 1'b1;
    step();
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
    deq_check("age_first", 1'b0, 6'd31);
    step();
    deq_check("age_second", 1'b0, 6'd32);
`else
    deq_check("age_first", 1'b0, 6'd32);
    step();
    deq_check("age_second", 1'b0, 6'd31);
`endif
    step();
    check("age_occ_end", 64'(occupancy), 64'd0);

    // Flush at robidx 4 with a concurrent enqueue of robidx 6
    deq_ready = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      enq(1'b0, ROB_W'(k), 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    enq(1'b0, 6'd6, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    deq_ready    = 1'b1;
    flush_valid  = 1'b1;
    flush_robidx = 6'd4;
    step();
    enq_valid    = 1'b0;
    flush_valid  = 1'b0;
    check("flush_deq_valid", 64'(deq_valid), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd2);
    step();
    deq_check("flush_keep3", 1'b0, 6'd3);
    step();
    deq_check("flush_keep4", 1'b0, 6'd4);
    step();
    check("flush_drained", 64'(deq_valid), 64'd0);
    check("flush_occ_end", 64'(occupancy), 64'd0);

    // Flag wrap against flush (flag 0, robidx 60)
    deq_ready = 1'b0;
    enq(1'b1, 6'd1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq(1'b1, 6'd61, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq(1'b0, 6'd59, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq(1'b0, 6'd61, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq_valid    = 1'b0;
    flush_valid  = 1'b1;
    flush_robidx = 6'd60;
    step();
    flush_valid  = 1'b0;
    check("wrap_occ", 64'(occupancy), 64'd2);
    deq_ready = 1'b1;
    step();
    deq_check("wrap_keep_f1_61", 1'b1, 6'd61);
    step();
    deq_check("wrap_keep_f0_59", 1'b0, 6'd59);
    step();
    check("wrap_drained", 64'(deq_valid), 64'd0);

    // Reset mid-operation discards stored entries
    deq_ready = 1'b0;
    enq(1'b0, 6'd40, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq(1'b0, 6'd41, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    enq_valid = 1'b0;
    check("pre_rst_occ", 64'(occupancy), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_enq_ready", 64'(enq_ready), 64'd1);
    check("mid_rst_deq_robidx", 64'(deq_robidx), 64'd0);
    deq_ready = 1'b1;
    step();
    step();
    check("mid_rst_no_issue", 64'(deq_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
